// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the MIPS controllers: opcodes, function codes, FSM states,
// ALU operations, datapath mux selects and the decoded instruction class.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LB    = 6'h20;
  localparam logic [5:0] OP_LH    = 6'h21;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SB    = 6'h28;
  localparam logic [5:0] OP_SH    = 6'h29;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5
  } state_t;

  typedef enum logic [3:0] {
    ALU_ADDU = 4'd0,
    ALU_SUBU = 4'd1,
    ALU_OR   = 4'd2,
    ALU_LUI  = 4'd3
  } alu_ctr_t;

  localparam logic [1:0] PC_SRC_SEQ    = 2'd0;
  localparam logic [1:0] PC_SRC_BRANCH = 2'd1;
  localparam logic [1:0] PC_SRC_JUMP   = 2'd2;
  localparam logic [1:0] PC_SRC_JR     = 2'd3;

  localparam logic [1:0] REG_DST_RT    = 2'd0;
  localparam logic [1:0] REG_DST_RD    = 2'd1;
  localparam logic [1:0] REG_DST_RA    = 2'd2;

  localparam logic [1:0] WB_SRC_ALU    = 2'd0;
  localparam logic [1:0] WB_SRC_MEM    = 2'd1;
  localparam logic [1:0] WB_SRC_PC4    = 2'd2;

  typedef enum logic [3:0] {
    IC_ADDU, IC_SUBU, IC_JR, IC_ORI, IC_LUI,
    IC_LW, IC_LH, IC_LB, IC_SW, IC_SH, IC_SB,
    IC_BEQ, IC_J, IC_JAL, IC_ILLEGAL
  } inst_class_t;

  function automatic logic is_load(input inst_class_t c);
    return c inside {IC_LW, IC_LH, IC_LB};
  endfunction

  function automatic logic is_store(input inst_class_t c);
    return c inside {IC_SW, IC_SH, IC_SB};
  endfunction

endpackage

// File: rtl/mips_multicycle_ctrl_if.sv
// Shared instruction/data memory port: the controller issues requests, memory answers with ready.
interface mips_multicycle_ctrl_if;
  logic mem_req;
  logic mem_we;
  logic halfword;
  logic byte_access;
  logic mem_ready;

  modport master (output mem_req, mem_we, halfword, byte_access, input mem_ready);
  modport slave  (input mem_req, mem_we, halfword, byte_access, output mem_ready);
endinterface

// File: rtl/mips_inst_decode.sv
// Combinational op/func classifier, shared by the multi-cycle and pipeline controllers.
module mips_inst_decode import mips_ctrl_pkg::*; #(
  parameter int OP_W = 6
) (
  input  logic [OP_W-1:0] op,
  input  logic [OP_W-1:0] func,
  output inst_class_t     inst_class,
  output logic            illegal
);

  always_comb begin
    inst_class = IC_ILLEGAL;
    case (op)
      OP_RTYPE: begin
        case (func)
          FN_ADDU: inst_class = IC_ADDU;
          FN_SUBU: inst_class = IC_SUBU;
          FN_JR:   inst_class = IC_JR;
          default: inst_class = IC_ILLEGAL;
        endcase
      end
      OP_J:    inst_class = IC_J;
      OP_JAL:  inst_class = IC_JAL;
      OP_BEQ:  inst_class = IC_BEQ;
      OP_ORI:  inst_class = IC_ORI;
      OP_LUI:  inst_class = IC_LUI;
      OP_LB:   inst_class = IC_LB;
      OP_LH:   inst_class = IC_LH;
      OP_LW:   inst_class = IC_LW;
      OP_SB:   inst_class = IC_SB;
      OP_SH:   inst_class = IC_SH;
      OP_SW:   inst_class = IC_SW;
      default: inst_class = IC_ILLEGAL;
    endcase
  end

  assign illegal = (inst_class == IC_ILLEGAL);

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS control FSM: fetch/decode/exec/mem/wb sequencing with a timed
// memory handshake, illegal-op and bus-error trapping, and a retired counter.
module mips_multicycle_ctrl import mips_ctrl_pkg::*; #(
  parameter int OP_W      = 6,
  parameter int ALU_CTR_W = 4,
  parameter int TIMEOUT   = 16,
  parameter int CNT_W     = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  mips_multicycle_ctrl_if.master mem,
  input  logic [OP_W-1:0]      op,
  input  logic [OP_W-1:0]      func,
  input  logic                 zero,
  output logic                 ir_write,
  output logic                 pc_write,
  output logic [1:0]           pc_src,
  output logic                 reg_write,
  output logic [1:0]           reg_dst,
  output logic [1:0]           wb_src,
  output logic                 alu_src_b,
  output logic                 ext_type,
  output logic                 shift16,
  output logic [ALU_CTR_W-1:0] alu_ctr,
  output logic [2:0]           state_o,
  output logic                 halted,
  output logic                 illegal,
  output logic                 bus_error,
  output logic [CNT_W-1:0]     retired
);

  localparam int WAIT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  state_t            state, state_next;
  inst_class_t       inst_class;
  alu_ctr_t          alu_op;
  logic              dec_illegal;
  logic              load, store;
  logic              waiting, timeout_hit, retire;
  logic [WAIT_W-1:0] wait_cnt;
  logic              illegal_q, bus_error_q;
  logic [CNT_W-1:0]  retired_q;

  mips_inst_decode #(.OP_W(OP_W)) u_decode (
    .op         (op),
    .func       (func),
    .inst_class (inst_class),
    .illegal    (dec_illegal)
  );

  assign load    = is_load(inst_class);
  assign store   = is_store(inst_class);
  assign waiting = mem.mem_req && !mem.mem_ready;
  // The wait counter only advances while stalled, so the TIMEOUT-th stalled cycle sees TIMEOUT-1.
  assign timeout_hit = (TIMEOUT != 0) && waiting && (wait_cnt == WAIT_W'(TIMEOUT - 1));

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) state <= ST_FETCH;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_FETCH: begin
        if (mem.mem_ready)    state_next = ST_DECODE;
        else if (timeout_hit) state_next = ST_HALT;
      end
      ST_DECODE: begin
        if (dec_illegal)                                state_next = ST_HALT;
        else if (inst_class inside {IC_J, IC_JAL, IC_JR}) state_next = ST_FETCH;
        else                                            state_next = ST_EXEC;
      end
      ST_EXEC: begin
        if (inst_class == IC_BEQ) state_next = ST_FETCH;
        else if (load || store)   state_next = ST_MEM;
        else                      state_next = ST_WB;
      end
      ST_MEM: begin
        if (mem.mem_ready)    state_next = store ? ST_FETCH : ST_WB;
        else if (timeout_hit) state_next = ST_HALT;
      end
      ST_WB:   state_next = ST_FETCH;
      ST_HALT: state_next = ST_HALT;
      default: state_next = ST_FETCH;
    endcase
  end

  // NOTE: every output gets a default before the case so no path can infer a latch.
  always_comb begin
    mem.mem_req     = 1'b0;
    mem.mem_we      = 1'b0;
    mem.halfword    = 1'b0;
    mem.byte_access = 1'b0;
    ir_write        = 1'b0;
    pc_write        = 1'b0;
    pc_src          = PC_SRC_SEQ;
    reg_write       = 1'b0;
    reg_dst         = REG_DST_RT;
    wb_src          = WB_SRC_ALU;
    alu_src_b       = 1'b0;
    ext_type        = 1'b0;
    shift16         = 1'b0;
    alu_op          = ALU_ADDU;
    retire          = 1'b0;
    // Reset masks all enables so a reset landing mid-instruction cannot commit a write.
    if (!reset) begin
      case (state)
        ST_FETCH: begin
          mem.mem_req = 1'b1;
          if (mem.mem_ready) begin
            ir_write = 1'b1;
            pc_write = 1'b1;
          end
        end
        ST_DECODE: begin
          case (inst_class)
            IC_J: begin
              pc_write = 1'b1;
              pc_src   = PC_SRC_JUMP;
              retire   = 1'b1;
            end
            IC_JAL: begin
              pc_write  = 1'b1;
              pc_src    = PC_SRC_JUMP;
              reg_write = 1'b1;
              reg_dst   = REG_DST_RA;
              wb_src    = WB_SRC_PC4;
              retire    = 1'b1;
            end
            IC_JR: begin
              pc_write = 1'b1;
              pc_src   = PC_SRC_JR;
              retire   = 1'b1;
            end
            default: ;
          endcase
        end
        ST_EXEC: begin
          case (inst_class)
            IC_ADDU: alu_op = ALU_ADDU;
            IC_SUBU: alu_op = ALU_SUBU;
            IC_ORI: begin
              alu_op    = ALU_OR;
              alu_src_b = 1'b1;
            end
            IC_LUI: begin
              alu_op    = ALU_LUI;
              alu_src_b = 1'b1;
              shift16   = 1'b1;
            end
            IC_BEQ: begin
              alu_op   = ALU_SUBU;
              ext_type = 1'b1;
              pc_write = zero;
              pc_src   = PC_SRC_BRANCH;
              retire   = 1'b1;
            end
            default: begin
              alu_op    = ALU_ADDU;
              alu_src_b = 1'b1;
              ext_type  = 1'b1;
            end
          endcase
        end
        ST_MEM: begin
          mem.mem_req     = 1'b1;
          mem.mem_we      = store;
          mem.halfword    = inst_class inside {IC_LH, IC_SH};
          mem.byte_access = inst_class inside {IC_LB, IC_SB};
          retire          = store && mem.mem_ready;
        end
        ST_WB: begin
          reg_write = 1'b1;
          reg_dst   = (inst_class inside {IC_ADDU, IC_SUBU}) ? REG_DST_RD : REG_DST_RT;
          wb_src    = load ? WB_SRC_MEM : WB_SRC_ALU;
          retire    = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt    <= '0;
      illegal_q   <= 1'b0;
      bus_error_q <= 1'b0;
      retired_q   <= '0;
    end else begin
      wait_cnt <= waiting ? wait_cnt + WAIT_W'(1) : '0;
      if (state == ST_DECODE && dec_illegal) illegal_q <= 1'b1;
      if (timeout_hit)                       bus_error_q <= 1'b1;
      if (retire)                            retired_q <= retired_q + CNT_W'(1);
    end
  end

  assign alu_ctr   = ALU_CTR_W'(alu_op);
  assign state_o   = state;
  assign halted    = !reset && (state == ST_HALT);
  assign illegal   = !reset && illegal_q;
  assign bus_error = !reset && bus_error_q;
  assign retired   = reset ? '0 : retired_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed bench for mips_multicycle_ctrl: walks instruction sequences cycle by cycle
// with TIMEOUT=4 and checks outputs against hand-computed values.
module tb_mips_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  op, func;
  logic        zero;
  logic        ir_write, pc_write, reg_write, alu_src_b, ext_type, shift16;
  logic [1:0]  pc_src, reg_dst, wb_src;
  logic [3:0]  alu_ctr;
  logic [2:0]  state_o;
  logic        halted, illegal, bus_error;
  logic [31:0] retired;
  logic [4:0]  en;

  int n_checks = 0;
  int n_errors = 0;

  mips_multicycle_ctrl_if mem_bus ();

  mips_multicycle_ctrl #(.OP_W(6), .ALU_CTR_W(4), .TIMEOUT(4), .CNT_W(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .mem       (mem_bus),
    .op        (op),
    .func      (func),
    .zero      (zero),
    .ir_write  (ir_write),
    .pc_write  (pc_write),
    .pc_src    (pc_src),
    .reg_write (reg_write),
    .reg_dst   (reg_dst),
    .wb_src    (wb_src),
    .alu_src_b (alu_src_b),
    .ext_type  (ext_type),
    .shift16   (shift16),
    .alu_ctr   (alu_ctr),
    .state_o   (state_o),
    .halted    (halted),
    .illegal   (illegal),
    .bus_error (bus_error),
    .retired   (retired)
  );

  always #5 clk = ~clk;

  // Enable bundle: {mem_req, mem_we, ir_write, pc_write, reg_write}
  assign en = {mem_bus.mem_req, mem_bus.mem_we, ir_write, pc_write, reg_write};

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    assert (observed === expected) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  initial begin
    reset = 1'b1; op = 6'h00; func = 6'h00; zero = 1'b0; mem_bus.mem_ready = 1'b0;
    cyc(); cyc();
    check("rst_state",   32'(state_o), 0);
    check("rst_en",      32'(en), 0);
    check("rst_retired", retired, 0);
    check("rst_flags",   32'({halted, illegal, bus_error}), 0);

    // addu with memory always ready: FETCH, DECODE, EXEC, WB
    reset = 1'b0; op = 6'h00; func = 6'h21; mem_bus.mem_ready = 1'b1; #1;
    check("addu_fetch_st", 32'(state_o), 0);
    check("addu_fetch_en", 32'(en), 32'b10110);
    check("addu_fetch_pcsrc", 32'(pc_src), 0);
    cyc();
    check("addu_dec_st", 32'(state_o), 1);
    check("addu_dec_en", 32'(en), 0);
    cyc();
    check("addu_exec_st", 32'(state_o), 2);
    check("addu_exec_alu", 32'({alu_ctr, alu_src_b}), 32'b0000_0);
    check("addu_exec_en", 32'(en), 0);
    cyc();
    check("addu_wb_st", 32'(state_o), 4);
    check("addu_wb_en", 32'(en), 32'b00001);
    check("addu_wb_sel", 32'({reg_dst, wb_src}), 32'b01_00);
    check("addu_wb_retired", retired, 0);
    cyc();
    check("addu_done_st", 32'(state_o), 0);
    check("addu_done_retired", retired, 1);

    // lw with three stalled MEM cycles: 8 cycles total
    op = 6'h23;
    cyc(); cyc();
    check("lw_exec", 32'({alu_ctr, alu_src_b, ext_type}), 32'b0000_1_1);
    mem_bus.mem_ready = 1'b0;
    cyc();
    check("lw_mem1_st", 32'(state_o), 3);
    check("lw_mem1_en", 32'(en), 32'b10000);
    check("lw_mem1_size", 32'({mem_bus.halfword, mem_bus.byte_access}), 0);
    cyc();
    check("lw_mem2_en", 32'(en), 32'b10000);
    cyc();
    check("lw_mem3_st", 32'(state_o), 3);
    mem_bus.mem_ready = 1'b1; #1;
    check("lw_mem4_en", 32'(en), 32'b10000);
    cyc();
    check("lw_wb_st", 32'(state_o), 4);
    check("lw_wb_en", 32'(en), 32'b00001);
    check("lw_wb_sel", 32'({reg_dst, wb_src}), 32'b00_01);
    cyc();
    check("lw_done", 32'({state_o, retired[3:0]}), 32'b000_0010);

    // beq taken, then not taken
    op = 6'h04; zero = 1'b1;
    cyc(); cyc();
    check("beq_t_exec", 32'({pc_write, pc_src, alu_ctr}), 32'b1_01_0001);
    cyc();
    check("beq_t_retired", retired, 3);
    check("beq_t_st", 32'(state_o), 0);
    zero = 1'b0;
    cyc(); cyc();
    check("beq_nt_exec", 32'({pc_write, pc_src}), 32'b0_01);
    cyc();
    check("beq_nt_retired", retired, 4);

    // sh: store retires from MEM
    op = 6'h29;
    cyc(); cyc(); cyc();
    check("sh_mem_en", 32'(en), 32'b11000);
    check("sh_mem_size", 32'({mem_bus.halfword, mem_bus.byte_access}), 32'b10);
    cyc();
    check("sh_done", 32'({state_o, retired[3:0]}), 32'b000_0101);

    // jal: everything happens in DECODE
    op = 6'h03;
    cyc();
    check("jal_dec_en", 32'(en), 32'b00011);
    check("jal_dec_sel", 32'({pc_src, reg_dst, wb_src}), 32'b10_10_10);
    cyc();
    check("jal_done", 32'({state_o, retired[3:0]}), 32'b000_0110);

    // lui
    op = 6'h0F;
    cyc(); cyc();
    check("lui_exec", 32'({alu_ctr, alu_src_b, shift16}), 32'b0011_1_1);
    cyc();
    check("lui_wb_dst", 32'({reg_dst, wb_src}), 0);
    cyc();
    check("lui_retired", retired, 7);

    // illegal opcode traps into HALT
    op = 6'h3F;
    cyc();
    check("ill_dec_en", 32'(en), 0);
    cyc();
    check("ill_halt_st", 32'(state_o), 5);
    check("ill_flags", 32'({halted, illegal, bus_error}), 32'b110);
    cyc(); cyc();
    check("ill_stay", 32'({state_o, en}), 32'b101_00000);
    check("ill_retired", retired, 7);
    reset = 1'b1; #1;
    check("ill_rst_flags", 32'({halted, illegal, bus_error}), 0);
    cyc();
    check("ill_rst_st", 32'({state_o, en}), 0);
    check("ill_rst_retired", retired, 0);

    // fetch timeout after 4 stalled cycles
    reset = 1'b0; mem_bus.mem_ready = 1'b0; op = 6'h00; func = 6'h21; #1;
    check("to_c1_en", 32'(en), 32'b10000);
    cyc(); cyc(); cyc();
    check("to_c4", 32'({state_o, bus_error}), 0);
    cyc();
    check("to_halt_st", 32'(state_o), 5);
    check("to_flags", 32'({halted, illegal, bus_error}), 32'b101);
    check("to_halt_en", 32'(en), 0);

    // ready arriving on the 4th stalled cycle wins over the timeout
    reset = 1'b1;
    cyc();
    reset = 1'b0; op = 6'h2B;
    cyc(); cyc(); cyc();
    mem_bus.mem_ready = 1'b1; #1;
    check("rdy_c4_en", 32'(en), 32'b10110);
    cyc();
    check("rdy_dec", 32'({state_o, bus_error}), 32'b001_0);

    // reset landing in MEM of sw
    cyc();
    mem_bus.mem_ready = 1'b0;
    cyc();
    check("sw_mem_en", 32'({state_o, en}), 32'b011_11000);
    reset = 1'b1; #1;
    check("sw_rst_mask", 32'(en), 0);
    cyc();
    check("sw_rst_st", 32'({state_o, en}), 0);
    check("sw_rst_retired", retired, 0);
    reset = 1'b0;
    cyc();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
